// File: rtl/rgb_hue_pwm.sv
// rgb_hue_pwm: RGB LED driver producing a six-segment hue wheel or a static
// colour, rendered as glitch-free PWM on three pads.
//
// Optional feature macro: RGB_PWM_BRIGHTNESS_EN
//   defined   -> latched duty = (raw * (bright + 1)) >> PWM_BITS
//   undefined -> latched duty = raw duty, bright is ignored
//
// Pads are combinational from registered on-states so that an asynchronous
// reset drives them to the inactive level without waiting for a clock.
module rgb_hue_pwm #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 12000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [PWM_BITS-1:0] static_r,
  input  logic [PWM_BITS-1:0] static_g,
  input  logic [PWM_BITS-1:0] static_b,
  input  logic [PWM_BITS-1:0] bright,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                wheel_wrap
);

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam int unsigned         PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);

  // Hue wheel segments, in rotation order
  typedef enum logic [2:0] {
    SEG_0 = 3'd0,
    SEG_1 = 3'd1,
    SEG_2 = 3'd2,
    SEG_3 = 3'd3,
    SEG_4 = 3'd4,
    SEG_5 = 3'd5
  } seg_e;

  logic [PRE_W-1:0]    pre_q,  pre_d;
  logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
  seg_e                seg_q,  seg_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                wrap_q, wrap_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
  logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
  logic [PWM_BITS-1:0] duty_b_q, duty_b_d;
  logic                on_r_q, on_r_d;
  logic                on_g_q, on_g_d;
  logic                on_b_q, on_b_d;

  logic                tick;
  logic                boundary;
  logic [PWM_BITS-1:0] raw_r, raw_g, raw_b;

  assign tick     = en && (pre_q == PRE_LAST);
  assign boundary = en && (pcnt_q == MAX);

`ifdef RGB_PWM_BRIGHTNESS_EN
  // Full-width product keeps bright = MAX an exact identity after the shift
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] raw,
                                                input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] prod;
    prod = (2*PWM_BITS)'(raw) * (2*PWM_BITS)'({1'b0, lvl} + (PWM_BITS+1)'(1));
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction
`else
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] raw,
                                                input logic [PWM_BITS-1:0] lvl);
    logic lvl_unused;
    lvl_unused = ^lvl;
    return raw;
  endfunction
`endif

  // Raw duties: static colour or the wheel position decoded per segment
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    raw_r = '0;
    raw_g = '0;
    raw_b = '0;
    if (mode) begin
      raw_r = static_r;
      raw_g = static_g;
      raw_b = static_b;
    end else begin
      unique case (seg_q)
        SEG_0: begin raw_r = MAX;          raw_g = ramp_q;       raw_b = '0;           end
        SEG_1: begin raw_r = MAX - ramp_q; raw_g = MAX;          raw_b = '0;           end
        SEG_2: begin raw_r = '0;           raw_g = MAX;          raw_b = ramp_q;       end
        SEG_3: begin raw_r = '0;           raw_g = MAX - ramp_q; raw_b = MAX;          end
        SEG_4: begin raw_r = ramp_q;       raw_g = '0;           raw_b = MAX;          end
        SEG_5: begin raw_r = MAX;          raw_g = '0;           raw_b = MAX - ramp_q; end
        default: begin raw_r = '0;         raw_g = '0;           raw_b = '0;           end
      endcase
    end
  end

  // Next state: prescaler, PWM counter and hue sequencer; en=0 blanks
  always_comb begin
    pre_d  = pre_q;
    pcnt_d = pcnt_q;
    seg_d  = seg_q;
    ramp_d = ramp_q;
    wrap_d = 1'b0;
    if (!en) begin
      pre_d  = '0;
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
      pre_d  = tick ? '0 : pre_q + 1'b1;
      if (tick && !mode) begin
        if (ramp_q == MAX) begin
          ramp_d = '0;
          if (seg_q == SEG_5) begin
            seg_d  = SEG_0;
            wrap_d = 1'b1;
          end else begin
            seg_d = seg_e'(seg_q + 3'd1);
          end
        end else begin
          ramp_d = ramp_q + 1'b1;
        end
      end
    end
  end

  // Duty latch only at the period boundary; on-states compare against latched duty
  always_comb begin
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    if (boundary) begin
      duty_r_d = scale(raw_r, bright);
      duty_g_d = scale(raw_g, bright);
      duty_b_d = scale(raw_b, bright);
    end
    on_r_d = en && (pcnt_q < duty_r_q);
    on_g_d = en && (pcnt_q < duty_g_q);
    on_b_d = en && (pcnt_q < duty_b_q);
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      pcnt_q   <= '0;
      seg_q    <= SEG_0;
      ramp_q   <= '0;
      wrap_q   <= 1'b0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
      on_r_q   <= 1'b0;
      on_g_q   <= 1'b0;
      on_b_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      seg_q    <= seg_d;
      ramp_q   <= ramp_d;
      wrap_q   <= wrap_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      on_r_q   <= on_r_d;
      on_g_q   <= on_g_d;
      on_b_q   <= on_b_d;
    end
  end

  assign RGB_R      = on_r_q ^ ACTIVE_LOW;
  assign RGB_G      = on_g_q ^ ACTIVE_LOW;
  assign RGB_B      = on_b_q ^ ACTIVE_LOW;
  assign wheel_wrap = wrap_q;

endmodule

// File: doc/rgb_hue_pwm.md
# rgb_hue_pwm

Parametrised RGB LED driver: generates a continuous six-segment hue wheel, or a static colour, and renders each channel as PWM on the on-board RGB LED pins. It is the next-generation replacement for the fixed top-level colour-cycling logic and sits directly between the board clock and the `RGB_R`/`RGB_G`/`RGB_B` pads. Duty resolution, hue step rate and output polarity are parameters. Optional global brightness scaling is available as a compile-time feature.

## Interface
- `PWM_BITS`, 8: duty and PWM counter width; full scale `MAX = 2^PWM_BITS-1`.
- `STEP_CYCLES`, 12000: clocks per hue ramp step (must be ≥1).
- `ACTIVE_LOW`, 1: 1 drives pads low for "on" (iCE40 RGB sink); 0 drives pads high for "on".

Ports:
- `clk` in 1: system clock (12 MHz on board).
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: 1 runs the block; 0 blanks the outputs.
- `mode` in 1: 0 selects hue wheel; 1 selects static colour.
- `static_r`, `static_g`, `static_b` in `PWM_BITS` each: duties used when `mode=1`.
- `bright` in `PWM_BITS`: global brightness. Ignored unless the feature macro is defined.
- `RGB_R`, `RGB_G`, `RGB_B` out 1: PWM pad drives, polarity set by `ACTIVE_LOW`.
- `wheel_wrap` out 1: one-cycle pulse when the hue wheel completes a full revolution.

## Operation
- Prescaler `pre` counts 0..STEP_CYCLES-1. `tick` is asserted in the cycle `pre == STEP_CYCLES-1`, then `pre` returns to 0.
- Hue sequencer holds `seg` (0..5) and `ramp` (`PWM_BITS` bits). It advances only on `tick` with `mode=0` and `en=1`.
  - `ramp` increments by 1 per tick.
  - When `ramp == MAX`: `ramp` goes to 0 and `seg` increments. From `seg=5`, `seg` goes to 0 and `wheel_wrap` pulses.
- Wheel duties (r = `ramp`):
  - seg0: R=MAX, G=r, B=0
  - seg1: R=MAX-r, G=MAX, B=0
  - seg2: R=0, G=MAX, B=r
  - seg3: R=0, G=MAX-r, B=MAX
  - seg4: R=r, G=0, B=MAX
  - seg5: R=MAX, G=0, B=MAX-r
- `mode=1`: raw duties are `static_*`. The sequencer freezes and keeps `seg`/`ramp`.
- PWM counter `pcnt` is `PWM_BITS` bits, free-running 0..MAX with natural wrap, so the period is 2^PWM_BITS clocks.
- Duty latch: `duty_*` registers load from raw duties only in the cycle `pcnt == MAX`. Duty therefore never changes mid-period, giving glitch-free PWM.
- Channel on-state: `on_x <= (pcnt < duty_x)`. Output is `RGB_x = on_x ^ ACTIVE_LOW`.
  - Duty 0 gives never on.
  - Duty MAX gives on for MAX of 2^PWM_BITS cycles.
- `en=0`:
  - synchronously clears `pcnt` and `pre`, and forces all `on_x` to 0;
  - `seg`, `ramp` and `duty_*` are held.
  - When `en` rises, counting restarts at `pcnt=0`.

## Timing
- Reset values: `pre`, `pcnt`, `seg`, `ramp`, `duty_*`, `on_*` and `wheel_wrap` all 0. Pads sit at the inactive level (`ACTIVE_LOW=1` gives 1).
- Output latency: registered, 1 clock from `pcnt`/`duty` to pad.
- Raw-duty change to pad takes effect at the first period boundary after it. Worst case is 2^PWM_BITS+1 clocks.
- `wheel_wrap` is high for exactly one clock, coinciding with the tick that moves `seg` from 5 to 0.
- Full wheel revolution takes 6·2^PWM_BITS·STEP_CYCLES clocks.
- Simultaneous `tick` and `pcnt==MAX`: the latch captures the pre-tick raw duty, and the new ramp value appears one period later.
- `mode` or `en` toggles mid-period: raw duty follows immediately, the latch waits for the boundary. `en=0` blanking acts on the next clock.
- `rst_n` low mid-operation: all state clears immediately (asynchronously) and pads go inactive without waiting for a clock.

## Configuration
- `RGB_PWM_BRIGHTNESS_EN`
  - Defined: latched duty is `(raw·(bright+1)) >> PWM_BITS`. This uses a 2·PWM_BITS-bit product, truncated. `bright=MAX` gives unscaled duty and `bright=0` gives `raw>>PWM_BITS`, which is 0.
  - Undefined: `bright` is unused and the latched duty equals the raw duty.

## Test plan
- Reset: `PWM_BITS=4`, `rst_n=0` asynchronously mid-period → all pads 1 (with `ACTIVE_LOW=1`) before the next edge; `seg=ramp=0`.
- Static colour: `mode=1`, `static_r=4`, `static_g=15`, `static_b=0`, `PWM_BITS=4` → per 16-clock period R on 4 clocks, G on 15, B on 0. Pad pattern is stable period-to-period.
- Wheel sweep: `mode=0`, `PWM_BITS=4`, `STEP_CYCLES=2` → seg advances every 32 clocks. At seg1 with ramp 5, latched duties are R=10, G=15, B=0. `wheel_wrap` pulses once per 192 clocks.
- Glitch-free latch: change `static_r` from 2 to 12 at `pcnt=5` → the current period still shows 2 on-clocks and the next period shows 12.
- Enable gating: drop `en` for 10 clocks mid-wheel → pads inactive, `seg`/`ramp` unchanged. After re-enable, `pcnt` restarts at 0.
- Brightness (macro defined): `static_r=15`, `bright=7`, `PWM_BITS=4` → duty 7. With the macro undefined, duty is 15.
